// File: rtl/uart_output_manager.sv
// uart_output_manager: serializes a DIGIT_COUNT-nibble value as uppercase ASCII hex characters
// over 8N1 UART frames, least significant nibble first.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   in     in   value to transmit, latched on an accepted start
//   start  in   request pulse, accepted only while busy is low
//   RsTx   out  registered UART line, idle high
//   busy   out  high for the whole transfer
//   done   out  one-cycle pulse on the completion edge
//
// Optional feature: define UART_OUT_CRLF_EN to append CR (0x0D) and LF (0x0A) frames after the
// digit characters.
module uart_output_manager #(
  parameter int unsigned CLOCK_RATE  = 100_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DIGIT_COUNT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIGIT_COUNT*4-1:0] in,
  input  logic                     start,
  output logic                     RsTx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BitCycles = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
`ifdef UART_OUT_CRLF_EN
  localparam int unsigned NumChars  = DIGIT_COUNT + 2;
`else
  localparam int unsigned NumChars  = DIGIT_COUNT;
`endif
  localparam int unsigned IdxW      = (NumChars > 1) ? $clog2(NumChars) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BitCycles - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumChars - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [IdxW-1:0]          char_idx_q, char_idx_d;
  logic [DIGIT_COUNT*4-1:0] hold_q, hold_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [DIGIT_COUNT*4-1:0] hold_shift;
  logic [3:0]               nibble;
  logic [7:0]               char_byte;
  logic                     cnt_wrap;

  assign cnt_wrap = (cnt_q == CntLast);

  // Character currently being framed; indices past the digits select the terminators.
  always_comb begin
    hold_shift = hold_q >> {char_idx_q, 2'b00};
    nibble     = hold_shift[3:0];
    char_byte  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
`ifdef UART_OUT_CRLF_EN
    if (char_idx_q == IdxW'(DIGIT_COUNT)) begin
      char_byte = 8'h0D;
    end else if (char_idx_q == IdxW'(DIGIT_COUNT + 1)) begin
      char_byte = 8'h0A;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);
    end

    // tx_d is set one edge ahead so the line changes exactly on the bit boundary.
    unique case (state_q)
      StIdle: begin
        if (start) begin
          hold_d     = in;
          char_idx_d = '0;
          cnt_d      = '0;
          bit_idx_d  = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (cnt_wrap) begin
          bit_idx_d = '0;
          tx_d      = char_byte[0];
          state_d   = StData;
        end
      end
      StData: begin
        if (cnt_wrap) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = char_byte[bit_idx_q + 3'd1];
          end
        end
      end
      StStop: begin
        if (cnt_wrap) begin
          if (char_idx_q == IdxLast) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            char_idx_d = char_idx_q + IdxW'(1);
            tx_d       = 1'b0;
            state_d    = StStart;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      hold_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign RsTx = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/uart_output_manager.md
# uart_output_manager

Transmit-side companion to the UART hex-digit input manager. Accepts a `DIGIT_COUNT`-nibble value on a one-cycle `start` request, converts each nibble to an uppercase ASCII hex character, and serializes the characters on `RsTx` as 8N1 UART frames. Sits between the display/compute logic and the board's UART TX pin. Nibble order matches the receiver's ordering, so a loopback through the input manager reproduces the original value.

## Interface
- `CLOCK_RATE`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate. Bit period is `BIT_CYCLES = CLOCK_RATE / BAUD_RATE` clocks (integer division, ≥ 2).
- `DIGIT_COUNT`, default 4: number of hex digits per transfer (≥ 1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in`  in  `DIGIT_COUNT*4`  value to transmit; sampled only on an accepted `start`.
- `start`  in  1  request pulse; accepted only when `busy` = 0.
- `RsTx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse on transfer completion.

## Operation
- Reset (reset low, asynchronous): `RsTx` = 1, `busy` = 0, `done` = 0, state IDLE, all counters and the holding register cleared.
- FSM states:
  - IDLE: waits for `start`.
  - START_BIT: line low for `BIT_CYCLES`.
  - DATA_BITS: 8 bits, LSB first, `BIT_CYCLES` each.
  - STOP_BIT: line high for `BIT_CYCLES`.
- Accepted `start`: latch `in` into the holding register, clear the character index, enter START_BIT.
- Character k (k = 0 first) is the encoding of nibble `in[4k+3:4k]`. Least significant nibble goes first.
- Encoding: 0–9 map to 0x30–0x39; 10–15 map to 0x41–0x46 (uppercase).
- End of STOP_BIT:
  - If more characters remain: increment the index and go to START_BIT. No idle gap.
  - Otherwise: go to IDLE, pulse `done`.
- `start` while `busy` = 1: ignored. Changes on `in` during a transfer have no effect.
- Bit-period counter: counts 0..`BIT_CYCLES`-1, wraps, and advances the bit index on the wrap.

## Timing
- `start` sampled high at edge T with `busy` = 0:
  - From edge T: `RsTx` = 0 and `busy` = 1.
  - Latency is 1 clock.
- Each frame lasts exactly 10·`BIT_CYCLES` clocks. Total `busy` time is N·10·`BIT_CYCLES` clocks, where N is the number of characters in the transfer.
- Completion edge (last stop-bit clock): `busy` falls to 0 and `done` is 1 for exactly one cycle. `RsTx` stays 1.
- `start` high in the `done` cycle is accepted (`busy` = 0). This gives back-to-back transfers with no idle bit time.
- Reset asserted mid-frame: `RsTx` returns high immediately. No `done` is issued. The partial frame is abandoned.
- `RsTx` is driven from a register (glitch-free).

## Configuration
- `UART_OUT_CRLF_EN`:
  - Defined: after the `DIGIT_COUNT` digit characters, two further frames are sent, 0x0D then 0x0A. N = `DIGIT_COUNT` + 2, and `done` fires after the LF stop bit.
  - Undefined: N = `DIGIT_COUNT`, with no terminator characters.

## Test plan
Bench parameters: `CLOCK_RATE`=16, `BAUD_RATE`=1 (`BIT_CYCLES`=16), `DIGIT_COUNT`=4.

- Reset then idle, no `start` → `RsTx`=1, `busy`=0, `done`=0 for 200 cycles.
- `in`=16'h1A2F, `start` pulse → `RsTx` shows four frames carrying 0x46, 0x32, 0x41, 0x31.
  - First frame bits after start bit, LSB first: 0,1,1,0,0,0,1,0.
  - `busy` high for exactly 640 cycles, then a single-cycle `done`.
- `start` pulses at cycles 50 and 300 during a transfer, and `in` changed mid-transfer → frames unchanged, only one `done`.
- `start` asserted in the `done` cycle with `in`=16'h0009 → the next start bit begins at that edge, carrying 0x39, 0x30, 0x30, 0x30.
- Reset low at cycle 70 of a transfer → `RsTx`=1 and `busy`=0 asynchronously. After release, a new `start` transmits correctly.
- Loopback: `RsTx` feeds the UART input manager. For `in` values 16'hBEEF and 16'h0000, the receiver output equals `in` and its ready pulses once per transfer. With `UART_OUT_CRLF_EN`, check for 0x0D, 0x0A after the digits and 960 busy cycles.
